// File: rtl/decoder_pkg.sv
// Shared types and defaults for the sequential binary-to-one-hot decoder.
// The one-hot check is shared by RTL assertions and reusable elsewhere.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int unsigned DEF_IN_W  = 2;
  localparam int unsigned DEF_HOLD  = 4;
  localparam int unsigned DEF_DEPTH = 4;

  // True when at most one bit of v is set.
  function automatic logic is_onehot0(input logic [31:0] v);
    return (v & 32'(v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; pushes while full and
// pops while empty are ignored, so there is no pass-through when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/decoder2to4_seq.sv
// Buffers binary codes from a valid/ready producer and replays each one as a
// one-hot strobe held for HOLD cycles; back-to-back codes leave no zero gap.
module decoder2to4_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned IN_W  = DEF_IN_W,
  parameter  int unsigned HOLD  = DEF_HOLD,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned OUT_W = 1 << IN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         data_in,
  output logic [OUT_W-1:0]        data_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_t             state_q, state_d;
  logic [HCNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               out_valid_q;
  logic               fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [IN_W-1:0]    fifo_rdata;

  sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == decoder_pkg::HOLD) || !fifo_empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      decoder_pkg::IDLE: begin
        data_d = '0;
        if (en && !fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = OUT_W'(1) << fifo_rdata;
          cnt_d    = HCNT_W'(HOLD - 1);
          state_d  = decoder_pkg::HOLD;
        end
      end
      decoder_pkg::HOLD: begin
        if (!en) begin
          // Abort drops the code in flight but leaves queued codes alone.
          data_d  = '0;
          cnt_d   = '0;
          state_d = decoder_pkg::IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HCNT_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = OUT_W'(1) << fifo_rdata;
          cnt_d    = HCNT_W'(HOLD - 1);
        end else begin
          data_d  = '0;
          state_d = decoder_pkg::IDLE;
        end
      end
      default: begin
        data_d  = '0;
        cnt_d   = '0;
        state_d = decoder_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= decoder_pkg::IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_valid_q <= |data_d;
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    is_onehot0(32'(data_out)));

endmodule
